ddr_out_sched: RTL and testbench

Sequences 2·WIDTH-bit result words (e.g. 14-bit m7q7 products) onto the DDR output mux. The mux presents `pos` while `clk` is high and `neg` while `clk` is low. The block buffers up to DEPTH words and splits each into lo/hi halves on the `pos`/`neg` lanes. It holds each word for a programmable number of cycles, optionally separates words with a one-cycle idle gap, and drives a fixed idle pattern when it has nothing to show. It sits between the multiplier result stage and `mux_clk_edge_out`.

---
 rtl/ddr_out_sched_pkg.sv | 19 +
 rtl/ddr_out_sched_if.sv | 16 +
 rtl/ddr_out_sched_fifo.sv | 54 +++++
 rtl/ddr_out_sched.sv | 104 ++++++++++
 tb/tb_ddr_out_sched.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_out_sched_pkg.sv
// Shared definitions for the DDR output scheduler: FSM encoding, idle patterns, helpers.
package ddr_out_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SHOW = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   localparam int          HOLD_W       = 4;
   localparam logic [6:0]  DEF_IDLE_POS = 7'h40;
   localparam logic [6:0]  DEF_IDLE_NEG = 7'h00;

   // Pointer width that stays legal for a single-entry FIFO.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/ddr_out_sched_if.sv
// Producer-side bus into the scheduler: word handshake plus per-word display controls.
interface ddr_out_sched_if #(
   parameter int WIDTH = 7
) ();
   import ddr_out_sched_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [2*WIDTH-1:0]   in_data;
   logic [HOLD_W-1:0]    hold;
   logic                 gap_en;
   logic                 swap;

   modport master (output in_valid, in_data, hold, gap_en, swap, input in_ready);
   modport slave  (input in_valid, in_data, hold, gap_en, swap, output in_ready);
endinterface

// File: rtl/ddr_out_sched_fifo.sv
// Small registered FIFO with wrapping head/tail pointers; push/pop are ignored when full/empty.
module sync_fifo_small
   import ddr_out_sched_pkg::*;
#(
   parameter int WIDTH_D = 14,
   parameter int DEPTH   = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH_D-1:0]         din,
   output logic [WIDTH_D-1:0]         dout,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int PW = ptr_w(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [DEPTH-1:0][WIDTH_D-1:0] mem;
   logic [PW-1:0]                 head, tail;
   logic                          do_push, do_pop;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[head];

   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            mem[tail] <= din;
            tail      <= inc(tail);
         end
         if (do_pop)
            head <= inc(head);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/ddr_out_sched.sv
// Buffers result words and shows each one as lo/hi halves on the pos/neg lanes of the DDR mux,
// with a programmable hold, optional idle gap and an idle pattern when nothing is queued.
module ddr_out_sched
   import ddr_out_sched_pkg::*;
#(
   parameter int               WIDTH    = 7,
   parameter int               DEPTH    = 2,
   parameter logic [WIDTH-1:0] IDLE_POS = WIDTH'(DEF_IDLE_POS),
   parameter logic [WIDTH-1:0] IDLE_NEG = WIDTH'(DEF_IDLE_NEG)
) (
   input  logic             clk,
   input  logic             rst,
   ddr_out_sched_if.slave   bus,
   output logic [WIDTH-1:0] pos,
   output logic [WIDTH-1:0] neg,
   output logic             word_strobe,
   output logic             busy
);
   localparam int CW = $clog2(DEPTH+1);

   state_e             state_q, state_d;
   logic [HOLD_W-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0]   pos_d, neg_d;
   logic               strobe_d;
   logic               push, pop, full, empty;
   logic [2*WIDTH-1:0] head;
   logic [CW-1:0]      count;

   // No pass-through: a slot freed by this edge's pop is only offered next cycle.
   assign bus.in_ready = !full && !rst;
   assign push         = bus.in_valid && bus.in_ready;
   assign busy         = (state_q != ST_IDLE) || (count != '0);

   sync_fifo_small #(.WIDTH_D(2*WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (bus.in_data),
      .dout  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pos_d    = pos;
      neg_d    = neg;
      strobe_d = 1'b0;
      pop      = 1'b0;
      case (state_q)
         ST_SHOW: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - HOLD_W'(1);
            end else if (bus.gap_en) begin
               state_d = ST_GAP;
               pos_d   = IDLE_POS;
               neg_d   = IDLE_NEG;
            end else if (!empty) begin
               pop = 1'b1;
            end else begin
               state_d = ST_IDLE;
               pos_d   = IDLE_POS;
               neg_d   = IDLE_NEG;
            end
         end
         default: begin
            // IDLE and the single GAP cycle share the same launch decision.
            if (!empty) begin
               pop = 1'b1;
            end else begin
               state_d = ST_IDLE;
               pos_d   = IDLE_POS;
               neg_d   = IDLE_NEG;
            end
         end
      endcase
      if (pop) begin
         state_d  = ST_SHOW;
         cnt_d    = bus.hold;
         strobe_d = 1'b1;
         pos_d    = bus.swap ? head[2*WIDTH-1:WIDTH] : head[WIDTH-1:0];
         neg_d    = bus.swap ? head[WIDTH-1:0]       : head[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         pos         <= IDLE_POS;
         neg         <= IDLE_NEG;
         word_strobe <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pos         <= pos_d;
         neg         <= neg_d;
         word_strobe <= strobe_d;
      end
   end
endmodule

// File: tb/tb_ddr_out_sched.sv
// Randomized scoreboard bench for ddr_out_sched: the driver queues expected word displays,
// a negedge monitor walks the expected lane timeline and compares every cycle.
module tb_ddr_out_sched;
   import ddr_out_sched_pkg::*;

   localparam int         W  = 7;
   localparam int         D  = 2;
   localparam logic [6:0] IP = 7'h40;
   localparam logic [6:0] IN = 7'h00;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] pos, neg;
   logic         word_strobe, busy;

   ddr_out_sched_if #(.WIDTH(W)) bus ();

   ddr_out_sched #(.WIDTH(W), .DEPTH(D), .IDLE_POS(IP), .IDLE_NEG(IN)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.slave),
      .pos         (pos),
      .neg         (neg),
      .word_strobe (word_strobe),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] p;
      logic [W-1:0] n;
      int           hold;
      bit           gap;
      int           tag;   // edge at which the word entered the FIFO
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
      end
   endtask

   // Monitor: reference timeline of what the lanes must show this cycle.
   bit   prev_rst = 1'b1;
   bit   in_word  = 1'b0;
   bit   gap_pend = 1'b0;
   int   rem      = 0;
   exp_t cur;

   always @(negedge clk) begin : mon
      bit act;
      act = 1'b0;
      if (prev_rst) begin
         chk("rst_pos", 32'(pos), 32'(IP));
         chk("rst_neg", 32'(neg), 32'(IN));
         chk("rst_strobe", 32'(word_strobe), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         exp_q.delete();
         in_word  = 1'b0;
         gap_pend = 1'b0;
         rem      = 0;
      end else begin
         if (in_word && rem > 0) begin
            chk("hold_strobe", 32'(word_strobe), 32'd0);
            chk("hold_pos", 32'(pos), 32'(cur.p));
            chk("hold_neg", 32'(neg), 32'(cur.n));
            rem--;
            act = 1'b1;
         end else if (in_word && gap_pend) begin
            chk("gap_pos", 32'(pos), 32'(IP));
            chk("gap_neg", 32'(neg), 32'(IN));
            chk("gap_strobe", 32'(word_strobe), 32'd0);
            in_word  = 1'b0;
            gap_pend = 1'b0;
            act      = 1'b1;
         end else if (exp_q.size() > 0 && exp_q[0].tag < cyc) begin
            cur = exp_q.pop_front();
            chk("load_strobe", 32'(word_strobe), 32'd1);
            chk("load_pos", 32'(pos), 32'(cur.p));
            chk("load_neg", 32'(neg), 32'(cur.n));
            rem      = cur.hold;
            gap_pend = cur.gap;
            in_word  = 1'b1;
            act      = 1'b1;
         end else begin
            chk("idle_pos", 32'(pos), 32'(IP));
            chk("idle_neg", 32'(neg), 32'(IN));
            chk("idle_strobe", 32'(word_strobe), 32'd0);
            in_word = 1'b0;
         end
         chk("busy", 32'(busy), 32'(act || exp_q.size() != 0));
      end
      chk("in_ready", 32'(bus.in_ready), 32'(!rst && exp_q.size() < D));
      prev_rst = rst;
   end

   task automatic set_cfg(input int h, input bit g, input bit s);
      bus.hold   = HOLD_W'(h);
      bus.gap_en = g;
      bus.swap   = s;
   endtask

   // Offer one word until accepted; records the expected display when the handshake lands.
   task automatic push_word(input logic [2*W-1:0] d);
      int   waited;
      bit   done;
      exp_t e;
      waited = 0;
      done   = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      while (!done) begin
         @(negedge clk);
         #2;
         if (bus.in_ready) begin
            e.p   = bus.swap ? d[2*W-1:W] : d[W-1:0];
            e.n   = bus.swap ? d[W-1:0]   : d[2*W-1:W];
            e.hold = int'(bus.hold);
            e.gap  = bus.gap_en;
            e.tag  = cyc + 1;
            exp_q.push_back(e);
            done = 1'b1;
         end else if (++waited > 100) begin
            checks++;
            failures++;
            $display("FAIL push_timeout cyc=%0d got=in_ready_low exp=accept", cyc);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || in_word || busy) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 300) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout cyc=%0d got=busy exp=idle", cyc);
      end
      repeat (2) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      set_cfg(0, 1'b0, 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      set_cfg(0, 1'b0, 1'b0);
      push_word(14'h1A5B);
      wait_idle();
      set_cfg(0, 1'b0, 1'b1);
      push_word(14'h1A5B);
      wait_idle();

      set_cfg(3, 1'b0, 1'b0);
      push_word(14'h2C3D);
      wait_idle();

      set_cfg(0, 1'b1, 1'b0);
      push_word(14'h0123);
      push_word(14'h1456);
      push_word(14'h2789);
      wait_idle();

      set_cfg(15, 1'b0, 1'b0);
      push_word(14'h3001);
      push_word(14'h3102);
      push_word(14'h3203);
      push_word(14'h3304);
      wait_idle();

      for (int b = 0; b < 6; b++) begin
         set_cfg(int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
         for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
            push_word(14'($urandom));
         end
         wait_idle();
      end

      // Reset lands in the second display cycle of W0 with two words queued.
      set_cfg(5, 1'b0, 1'b0);
      push_word(14'h0A0B);
      push_word(14'h0C0D);
      push_word(14'h0E0F);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      set_cfg(0, 1'b0, 1'b0);
      push_word(14'h1111);
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
